// File: rtl/shift_scheduler.sv
// ---------------------------------------------------------------------------
// shift_scheduler
//
// Purpose:
//   Shares one iterative Shifter datapath among R requesters. A round-robin
//   arbiter picks one pending op while idle, latches its operands, pulses
//   the Shifter start and holds its controls stable for the whole run. The
//   result is captured on the Shifter's finished flag and returned to the
//   requester that owns it over a valid/ready response channel.
//
// Parameters:
//   N  data and iteration-count width (must match the attached Shifter)
//   R  number of requesters (>= 2)
//
// Ports:
//   i_clock             clock, all state on the rising edge
//   i_reset             asynchronous active-low reset
//   i_req_valid[R]      per-requester op pending
//   o_req_ready[R]      one-hot grant, only while idle
//   i_req_direction[R]  per-requester direction (1 = left)
//   i_req_rotate[R]     per-requester mode (1 = rotate)
//   i_req_iterations    R packed N-bit shift counts
//   i_req_value         R packed N-bit operands
//   o_resp_valid[R]     one-hot result valid toward the owner
//   i_resp_ready[R]     per-requester result accept
//   o_resp_value[N]     captured result, shared by all requesters
//   o_busy              high whenever the scheduler is not idle
//   o_shift_*           start pulse and held controls toward the Shifter
//   i_shift_finished    Shifter done flag
//   i_shift_value       Shifter result
// ---------------------------------------------------------------------------
module shift_scheduler #(
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic [R-1:0]   i_req_valid,
    output logic [R-1:0]   o_req_ready,
    input  logic [R-1:0]   i_req_direction,
    input  logic [R-1:0]   i_req_rotate,
    input  logic [R*N-1:0] i_req_iterations,
    input  logic [R*N-1:0] i_req_value,
    output logic [R-1:0]   o_resp_valid,
    input  logic [R-1:0]   i_resp_ready,
    output logic [N-1:0]   o_resp_value,
    output logic           o_busy,
    output logic           o_shift_start,
    output logic           o_shift_direction,
    output logic           o_shift_rotate,
    output logic [N-1:0]   o_shift_iterations,
    output logic [N-1:0]   o_shift_value,
    input  logic           i_shift_finished,
    input  logic [N-1:0]   i_shift_value
);

    localparam int PW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic            dir_q, dir_d;
    logic            rot_q, rot_d;
    logic [N-1:0]    iter_q, iter_d;
    logic [N-1:0]    value_q, value_d;
    logic [N-1:0]    result_q, result_d;

    logic            grant_found;
    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   grant_next;
    logic [R-1:0]    grant_onehot;

    // Index of the requester 'offset' places after 'base', wrapping at R
    // (R need not be a power of two, so plain bit truncation is not enough).
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= R) begin
            sum = sum - R;
        end
        return PW'(sum);
    endfunction

    // Round-robin scan starting at the pointer; first pending requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < R; i++) begin
            if (!grant_found && i_req_valid[wrap_idx(ptr_q, i)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(ptr_q, i);
            end
        end
        grant_onehot = grant_found ? (R'(1) << grant_idx) : '0;
        grant_next   = wrap_idx(grant_idx, 1);
    end

    // State and latch registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            dir_q    <= 1'b0;
            rot_q    <= 1'b0;
            iter_q   <= '0;
            value_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            dir_q    <= dir_d;
            rot_q    <= rot_d;
            iter_q   <= iter_d;
            value_q  <= value_d;
            result_q <= result_d;
        end
    end

    // Next-state logic. A finished flag already present in START means K was
    // zero and the Shifter is passing the operand straight through.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (grant_found) state_d = START;
            START: state_d = i_shift_finished ? RESP : RUN;
            RUN:   if (i_shift_finished) state_d = RESP;
            RESP:  if (i_resp_ready[owner_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latching on accept and result capture on finished. The
    // finished flag is only looked at in START and RUN, since the Shifter
    // counter keeps running and may raise it again at any time.
    always_comb begin
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        dir_d    = dir_q;
        rot_d    = rot_q;
        iter_d   = iter_q;
        value_d  = value_q;
        result_d = result_q;
        if (state_q == IDLE && grant_found) begin
            ptr_d   = grant_next;
            owner_d = grant_idx;
            dir_d   = i_req_direction[grant_idx];
            rot_d   = i_req_rotate[grant_idx];
            iter_d  = i_req_iterations[int'(grant_idx)*N +: N];
            value_d = i_req_value[int'(grant_idx)*N +: N];
        end
        if ((state_q == START || state_q == RUN) && i_shift_finished) begin
            result_d = i_shift_value;
        end
    end

    // Outputs. The grant is gated by reset so that every output is zero
    // while reset is held, even though the state already reads IDLE.
    always_comb begin
        o_req_ready        = (state_q == IDLE && i_reset) ? grant_onehot : '0;
        o_busy             = (state_q != IDLE);
        o_shift_start      = (state_q == START);
        o_resp_valid       = (state_q == RESP) ? (R'(1) << owner_q) : '0;
        o_resp_value       = result_q;
        o_shift_direction  = dir_q;
        o_shift_rotate     = rot_q;
        o_shift_iterations = iter_q;
        o_shift_value      = value_q;
    end

endmodule

// File: tb/tb_shift_scheduler.sv
// ---------------------------------------------------------------------------
// tb_shift_scheduler
//
// Purpose:
//   Directed bench for shift_scheduler with a behavioural Shifter attached.
//   Stimulus pushes the expected response for every accepted op into a
//   scoreboard queue; an independent monitor pops and compares it whenever
//   the scheduler presents a result.
// ---------------------------------------------------------------------------
module tb_shift_scheduler;

    localparam int N = 8;
    localparam int R = 4;

    logic           clk = 1'b0;
    logic           i_reset = 1'b0;
    logic [R-1:0]   i_req_valid = '0;
    logic [R-1:0]   o_req_ready;
    logic [R-1:0]   i_req_direction = '0;
    logic [R-1:0]   i_req_rotate = '0;
    logic [R*N-1:0] i_req_iterations = '0;
    logic [R*N-1:0] i_req_value = '0;
    logic [R-1:0]   o_resp_valid;
    logic [R-1:0]   i_resp_ready = '1;
    logic [N-1:0]   o_resp_value;
    logic           o_busy;
    logic           o_shift_start;
    logic           o_shift_direction;
    logic           o_shift_rotate;
    logic [N-1:0]   o_shift_iterations;
    logic [N-1:0]   o_shift_value;
    logic           sh_finished;
    logic [N-1:0]   sh_value;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    bit resp_seen = 1'b0;

    typedef struct {
        int         owner;
        logic [7:0] exp;
        int         acc;
        int         k;
        logic       dir;
        logic       rot;
        logic [7:0] opnd;
    } sb_t;

    sb_t sb[$];

    // Per-requester stimulus table, used when an accept is observed.
    logic       tbl_dir [R];
    logic       tbl_rot [R];
    logic [7:0] tbl_k   [R];
    logic [7:0] tbl_val [R];
    logic [7:0] tbl_exp [R];

    shift_scheduler #(.N(N), .R(R)) dut (
        .i_clock            (clk),
        .i_reset            (i_reset),
        .i_req_valid        (i_req_valid),
        .o_req_ready        (o_req_ready),
        .i_req_direction    (i_req_direction),
        .i_req_rotate       (i_req_rotate),
        .i_req_iterations   (i_req_iterations),
        .i_req_value        (i_req_value),
        .o_resp_valid       (o_resp_valid),
        .i_resp_ready       (i_resp_ready),
        .o_resp_value       (o_resp_value),
        .o_busy             (o_busy),
        .o_shift_start      (o_shift_start),
        .o_shift_direction  (o_shift_direction),
        .o_shift_rotate     (o_shift_rotate),
        .o_shift_iterations (o_shift_iterations),
        .o_shift_value      (o_shift_value),
        .i_shift_finished   (sh_finished),
        .i_shift_value      (sh_value)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural Shifter: one step per cycle after start; finished is
    // raised combinationally in the start cycle when K is zero.
    logic [N-1:0] sh_cur;
    int           sh_cnt;
    logic         sh_running;

    function automatic logic [N-1:0] step1(input logic [N-1:0] v, input logic d, input logic r);
        if (d) return {v[N-2:0], r ? v[N-1] : 1'b0};
        else   return {r ? v[0] : 1'b0, v[N-1:1]};
    endfunction

    always @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            sh_running <= 1'b0;
            sh_cur     <= '0;
            sh_cnt     <= 0;
        end else if (o_shift_start) begin
            if (o_shift_iterations != 0) begin
                sh_cur     <= step1(o_shift_value, o_shift_direction, o_shift_rotate);
                sh_cnt     <= 1;
                sh_running <= 1'b1;
            end
        end else if (sh_running) begin
            if (sh_cnt == int'(o_shift_iterations)) begin
                sh_running <= 1'b0;
            end else begin
                sh_cur <= step1(sh_cur, o_shift_direction, o_shift_rotate);
                sh_cnt <= sh_cnt + 1;
            end
        end
    end

    assign sh_finished = o_shift_start ? (o_shift_iterations == 0)
                                       : (sh_running && sh_cnt == int'(o_shift_iterations));
    assign sh_value    = o_shift_start ? o_shift_value : sh_cur;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Load one requester's op into the input buses and raise its valid.
    task automatic driveReq(input int r, input logic d, input logic rt, input logic [7:0] k,
                            input logic [7:0] v, input logic [7:0] e);
        tbl_dir[r] = d;
        tbl_rot[r] = rt;
        tbl_k[r]   = k;
        tbl_val[r] = v;
        tbl_exp[r] = e;
        i_req_direction[r]       = d;
        i_req_rotate[r]          = rt;
        i_req_iterations[r*N +: N] = k;
        i_req_value[r*N +: N]      = v;
        i_req_valid[r]           = 1'b1;
    endtask

    // Wait for a grant, check it went to requester r, push the expectation.
    task automatic acceptReq(input int r, input bit keep);
        bit got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (o_req_ready != 0) begin
                got = 1'b1;
                checkOutput($sformatf("grant_r%0d", r), 32'(o_req_ready), 32'(1 << r));
                last_acc = cyc;
                sb.push_back('{owner: r, exp: tbl_exp[r], acc: cyc, k: int'(tbl_k[r]),
                               dir: tbl_dir[r], rot: tbl_rot[r], opnd: tbl_val[r]});
            end
        end
        if (!got) checkOutput($sformatf("accept_timeout_r%0d", r), 32'd1, 32'd0);
        @(posedge clk);
        #1;
        if (!keep) i_req_valid[r] = 1'b0;
    endtask

    task automatic applyStimulus(input int r, input logic d, input logic rt, input logic [7:0] k,
                                 input logic [7:0] v, input logic [7:0] e);
        @(posedge clk);
        #1;
        driveReq(r, d, rt, k, v, e);
        acceptReq(r, 1'b0);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 600 && sb.size() != 0; i++) @(negedge clk);
        checkOutput("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic resetPulse();
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        sb.delete();
        resp_seen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b1;
    endtask

    // Scoreboard monitor: start pulses and responses are compared against
    // the head of the queue, including their cycle position.
    always @(negedge clk) begin
        if (i_reset) begin
            if (o_shift_start) begin
                if (sb.size() == 0) begin
                    checkOutput("start_unexpected", 32'd1, 32'd0);
                end else begin
                    checkOutput("start_cycle", 32'(cyc), 32'(sb[0].acc + 1));
                    checkOutput("shift_ctrl",
                        32'({o_shift_direction, o_shift_rotate, o_shift_iterations, o_shift_value}),
                        32'({sb[0].dir, sb[0].rot, 8'(sb[0].k), sb[0].opnd}));
                end
            end
            if (o_resp_valid != 0) begin
                if (sb.size() == 0) begin
                    checkOutput("resp_unexpected", 32'(o_resp_valid), 32'd0);
                end else begin
                    checkOutput("resp_owner", 32'(o_resp_valid), 32'(1 << sb[0].owner));
                    checkOutput("resp_value", 32'(o_resp_value), 32'(sb[0].exp));
                    checkOutput("resp_quiet", 32'({o_req_ready, o_shift_start, o_busy}), 32'd1);
                    if (!resp_seen) begin
                        checkOutput("resp_latency", 32'(cyc), 32'(sb[0].acc + 2 + sb[0].k));
                        resp_seen = 1'b1;
                    end
                    if (i_resp_ready[sb[0].owner]) begin
                        void'(sb.pop_front());
                        resp_seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int release_cyc;

        // Reset state, with a pending request that must not be granted.
        i_req_valid = 4'b0001;
        #12;
        checkOutput("reset_outputs",
            32'({o_req_ready, o_resp_valid, o_busy, o_shift_start, o_shift_direction,
                 o_shift_rotate, o_shift_iterations, o_shift_value, o_resp_value}), 32'd0);
        i_req_valid = '0;
        @(posedge clk);
        #1;
        i_reset = 1'b1;

        // Single op: rotate-left 0x81 by 1.
        applyStimulus(0, 1'b1, 1'b1, 8'd1, 8'h81, 8'h03);
        waitDrain();

        // K = 0 passes the operand through.
        applyStimulus(2, 1'b0, 1'b0, 8'd0, 8'hA5, 8'hA5);
        waitDrain();

        // Round robin with all four requesters held valid.
        resetPulse();
        @(posedge clk);
        #1;
        driveReq(0, 1'b1, 1'b0, 8'd2, 8'h01, 8'h04);
        driveReq(1, 1'b0, 1'b0, 8'd2, 8'h80, 8'h20);
        driveReq(2, 1'b1, 1'b1, 8'd2, 8'h81, 8'h06);
        driveReq(3, 1'b0, 1'b1, 8'd2, 8'h81, 8'h60);
        acceptReq(0, 1'b1);
        acceptReq(1, 1'b1);
        acceptReq(2, 1'b1);
        acceptReq(3, 1'b1);
        acceptReq(0, 1'b1);
        i_req_valid = '0;
        waitDrain();

        // Logical right shifts and the full-range count.
        applyStimulus(1, 1'b0, 1'b0, 8'd4, 8'hF0, 8'h0F);
        waitDrain();
        applyStimulus(1, 1'b0, 1'b0, 8'd8, 8'hF0, 8'h00);
        waitDrain();
        applyStimulus(3, 1'b1, 1'b1, 8'd255, 8'h81, 8'hC0);
        waitDrain();

        // Backpressure on requester 1 with requester 3 waiting behind it.
        applyStimulus(1, 1'b1, 1'b0, 8'd3, 8'h3C, 8'hE0);
        i_resp_ready = 4'b1101;
        driveReq(3, 1'b0, 1'b1, 8'd1, 8'h55, 8'hAA);
        for (int i = 0; i < 50 && !o_resp_valid[1]; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        checkOutput("bp_hold", 32'({o_resp_valid, o_resp_value}), 32'({4'b0010, 8'hE0}));
        @(posedge clk);
        #1;
        release_cyc = cyc;
        i_resp_ready = '1;
        acceptReq(3, 1'b0);
        checkOutput("bp_next_accept", 32'(last_acc), 32'(release_cyc + 1));
        waitDrain();

        // Reset in the middle of a long run aborts the op.
        applyStimulus(2, 1'b1, 1'b0, 8'd10, 8'h0F, 8'h00);
        repeat (3) @(posedge clk);
        #2;
        i_reset = 1'b0;
        sb.delete();
        resp_seen = 1'b0;
        #1;
        checkOutput("abort_outputs",
            32'({o_req_ready, o_resp_valid, o_busy, o_shift_start, o_shift_direction,
                 o_shift_rotate, o_shift_iterations, o_shift_value, o_resp_value}), 32'd0);
        @(posedge clk);
        #1;
        i_reset = 1'b1;
        repeat (15) @(negedge clk);
        checkOutput("abort_no_resp", 32'({o_resp_valid, o_busy}), 32'd0);
        applyStimulus(2, 1'b1, 1'b1, 8'd4, 8'h0F, 8'hF0);
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
